// File: rtl/repadd_feeder_pkg.sv
// Shared definitions for the repeated-addition multiplier feeder and its wrapper.
// Holds the 3-bit FSM state encoding and the default width / timeout bound.
// Imported by repadd_feeder and by the multiplier wrapper.
package repadd_feeder_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_A    = 3'd1;
  localparam logic [2:0] ST_LOAD_B    = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_HOLD      = 3'd4;

  localparam int DEF_W        = 16;
  localparam int DEF_MAX_WAIT = 1023;

endpackage

// File: rtl/repadd_feeder.sv
// Operand sequencer: takes an (A,B) pair, drives the multiplier start/din protocol, returns A*B mod 2^W.
// Latency: 1 cycle for a zero operand, otherwise 3 cycles plus the multiplier's run time.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready. Macro REPADD_FEED_TIMEOUT_EN adds a WAIT_DONE timeout.
module repadd_feeder
  import repadd_feeder_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         mul_start,
  output logic [W-1:0] mul_din,
  input  logic         mul_done,
  input  logic [W-1:0] mul_p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         out_bypass,
  output logic         err
);

  logic [2:0]   state;
  // A travels straight onto the din register at accept; only B needs its own copy.
  logic [W-1:0] b_q;

`ifdef REPADD_FEED_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic          wait_hit;

  // Last WAIT_DONE cycle before giving up: count runs 0..MAX_WAIT-1.
  assign wait_hit = (wait_cnt == CW'(MAX_WAIT - 1));
  assign err      = err_q;
`else
  // Timeout bound has no meaning without the counter.
  localparam int unused_max_wait = MAX_WAIT;
  assign err = 1'b0;
`endif

  // Only one operation in flight: new pairs are taken only when idle.
  assign in_ready = (state == ST_IDLE);

  // Sequencer FSM with the result holding register folded in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      b_q        <= '0;
      mul_start  <= 1'b0;
      mul_din    <= '0;
      out_valid  <= 1'b0;
      out_p      <= '0;
      out_bypass <= 1'b0;
`ifdef REPADD_FEED_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            b_q <= in_b;
            if ((in_a == '0) || (in_b == '0)) begin
              // Zero product is known without the multiplier; B=0 would also never finish there.
              state      <= ST_HOLD;
              out_valid  <= 1'b1;
              out_p      <= '0;
              out_bypass <= 1'b1;
            end else begin
              state     <= ST_LOAD_A;
              mul_start <= 1'b1;
              mul_din   <= in_a;
            end
          end
        end

        ST_LOAD_A: begin
          // mul_done is deliberately not looked at here: it may be left over from the last run.
          state   <= ST_LOAD_B;
          mul_din <= b_q;
        end

        ST_LOAD_B: begin
          state <= ST_WAIT_DONE;
`ifdef REPADD_FEED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ST_WAIT_DONE: begin
          if (mul_done) begin
            state      <= ST_HOLD;
            mul_start  <= 1'b0;
            out_valid  <= 1'b1;
            out_p      <= mul_p;
            out_bypass <= 1'b0;
`ifdef REPADD_FEED_TIMEOUT_EN
          end else if (wait_hit) begin
            state      <= ST_HOLD;
            mul_start  <= 1'b0;
            out_valid  <= 1'b1;
            out_p      <= '0;
            out_bypass <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end

        ST_HOLD: begin
          // start is already low here, which re-arms the multiplier controller.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
`ifdef REPADD_FEED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end

        default: begin
          state     <= ST_IDLE;
          mul_start <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repadd_feeder.sv
// Self-checking bench for repadd_feeder with a behavioural repeated-addition multiplier attached.
// Expected products come from plain arithmetic (A*B truncated to W bits); zero operands expect bypass.
// The multiplier can be swapped for directly driven done/product to exercise stale-done and timeout cases.
module tb_repadd_feeder;

  localparam int W     = 16;
  localparam int MAXW  = 20;
  localparam int LIMIT = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         mul_start;
  logic [W-1:0] mul_din;
  logic         mul_done;
  logic [W-1:0] mul_p;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_bypass;
  logic         err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  repadd_feeder #(.W(W), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_din(mul_din), .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_bypass(out_bypass), .err(err)
  );

  // Behavioural multiplier: latch A then B off din, add A B times, hold done until start drops.
  logic         manual;
  logic         man_done;
  logic [W-1:0] man_p;
  logic [1:0]   m_st;
  logic [W-1:0] m_a, m_b, m_p;
  logic         m_done;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_st <= 2'd0; m_done <= 1'b0; m_p <= '0; m_a <= '0; m_b <= '0;
    end else begin
      case (m_st)
        2'd0: if (mul_start) begin m_a <= mul_din; m_st <= 2'd1; end
        2'd1: if (!mul_start) m_st <= 2'd0;
              else begin m_b <= mul_din; m_p <= '0; m_st <= 2'd2; end
        2'd2: if (!mul_start) m_st <= 2'd0;
              else if (m_b == '0) begin m_done <= 1'b1; m_st <= 2'd3; end
              else begin m_p <= m_p + m_a; m_b <= m_b - 1'b1; end
        default: if (!mul_start) begin m_done <= 1'b0; m_st <= 2'd0; end
      endcase
    end
  end

  assign mul_done = manual ? man_done : m_done;
  assign mul_p    = manual ? man_p    : m_p;

  // Start monitor: din on the first and second start cycles, and number of start rises.
  int           start_len = 0;
  int           start_rises = 0;
  logic         start_q = 1'b0;
  logic [W-1:0] din_first, din_second;

  always @(negedge clk) begin
    if (mul_start === 1'b1) begin
      start_len = start_len + 1;
      if (start_len == 1) din_first = mul_din;
      if (start_len == 2) din_second = mul_din;
      if (start_q !== 1'b1) start_rises = start_rises + 1;
    end else begin
      start_len = 0;
    end
    start_q = mul_start;
  end

  // Drive one pair with out_ready high; returns captured result and cycles from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] p, output logic byp, output int lat, output bit to);
    to = 1'b0; in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (out_valid !== 1'b1 && lat < LIMIT) begin @(posedge clk); #1; lat++; end
    p = out_p; byp = out_bypass;
    if (out_valid !== 1'b1) begin to = 1'b1; return; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    manual = 1'b0; man_done = 1'b0; man_p = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start got %b want 0", mul_start); end
    checks++; if (mul_din !== '0) begin errors++; $display("FAIL reset_mul_din got %0d want 0", mul_din); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_p !== '0 || out_bypass !== 1'b0) begin errors++; $display("FAIL reset_out got p=%0d byp=%b want 0/0", out_p, out_bypass); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0] p; logic byp; int lat; bit to; int r0;
    r0 = start_rises;
    run_op(16'd9, 16'd7, p, byp, lat, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no out_valid want out_valid"); end
    checks++; if (p !== 16'd63 || byp !== 1'b0) begin errors++; $display("FAIL basic_prod got %0d/%b want 63/0", p, byp); end
    checks++; if (din_first !== 16'd9 || din_second !== 16'd7) begin errors++; $display("FAIL basic_din got %0d,%0d want 9,7", din_first, din_second); end
    checks++; if (start_rises - r0 != 1) begin errors++; $display("FAIL basic_start_rises got %0d want 1", start_rises - r0); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_one_cycle got valid=%b rdy=%b want 0/1", out_valid, in_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] av [2]; logic [W-1:0] bv [2];
    logic [W-1:0] p; logic byp; int lat; bit to; int r0;
    av[0] = 16'd0;  bv[0] = 16'd5;
    av[1] = 16'd12; bv[1] = 16'd0;
    for (int i = 0; i < 2; i++) begin
      r0 = start_rises;
      run_op(av[i], bv[i], p, byp, lat, to);
      checks++; if (to || lat != 1) begin errors++; $display("FAIL bypass_latency[%0d] got %0d want 1", i, lat); end
      checks++; if (p !== '0 || byp !== 1'b1) begin errors++; $display("FAIL bypass_result[%0d] got %0d/%b want 0/1", i, p, byp); end
      checks++; if (start_rises != r0) begin errors++; $display("FAIL bypass_no_start[%0d] got %0d rises want 0", i, start_rises - r0); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] p; logic byp; int lat; bit to;
    run_op(16'd300, 16'd300, p, byp, lat, to);
    checks++; if (to || p !== 16'd24464 || byp !== 1'b0) begin errors++; $display("FAIL wrap_prod got %0d/%b want 24464/0", p, byp); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] p0; logic b0; int n; bit ok; int r0;
    in_a = 16'd5; in_b = 16'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; n = 0;
    while (out_valid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    p0 = out_p; b0 = out_bypass;
    checks++; if (out_valid !== 1'b1 || p0 !== 16'd30) begin errors++; $display("FAIL bp_result got valid=%b p=%0d want 1/30", out_valid, p0); end
    in_a = 16'd2; in_b = 16'd3; in_valid = 1'b1; ok = 1'b1; r0 = start_rises;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_p !== p0 || out_bypass !== b0 || in_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_stable got valid=%b p=%0d rdy=%b want 1/%0d/0", out_valid, out_p, in_ready, p0); end
    checks++; if (start_rises != r0) begin errors++; $display("FAIL bp_no_accept got %0d rises want 0", start_rises - r0); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_handshake got valid=%b rdy=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got rdy=%b want 0", in_ready); end
    n = 0;
    while (out_valid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1 || out_p !== 16'd6) begin errors++; $display("FAIL bp_second got valid=%b p=%0d want 1/6", out_valid, out_p); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] p; logic byp; int lat; bit to;
    in_a = 16'd50; in_b = 16'd40; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (mul_start !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_busy got start=%b valid=%b want 1/0", mul_start, out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (mul_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_abort got start=%b valid=%b rdy=%b want 0/0/1", mul_start, out_valid, in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(16'd3, 16'd4, p, byp, lat, to);
    checks++; if (to || p !== 16'd12 || byp !== 1'b0) begin errors++; $display("FAIL rstmid_after got %0d/%b want 12/0", p, byp); end
  endtask

  task automatic test_stale_done();
    bit ok;
    manual = 1'b1; man_done = 1'b1; man_p = 16'hDEAD;
    in_a = 16'd4; in_b = 16'd5; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    man_done = 1'b0; ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (out_valid !== 1'b0 || mul_start !== 1'b1 || mul_din !== 16'd5) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL stale_ignored got valid=%b start=%b din=%0d want 0/1/5", out_valid, mul_start, mul_din); end
    man_p = 16'd20; man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_p !== 16'd20 || mul_start !== 1'b0) begin errors++; $display("FAIL stale_done got valid=%b p=%0d start=%b want 1/20/0", out_valid, out_p, mul_start); end
    @(posedge clk); #1;
    manual = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, p, exp_p; logic byp, exp_byp; int lat; bit to; int r0; logic [2*W-1:0] full;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom_range(0, 40));
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = '0;
        default: ;
      endcase
      full = (2*W)'(a) * (2*W)'(b);
      exp_p = full[W-1:0];
      exp_byp = (a == '0) || (b == '0);
      r0 = start_rises;
      run_op(a, b, p, byp, lat, to);
      checks++; if (to || p !== exp_p || byp !== exp_byp) begin errors++; $display("FAIL rand_prod[%0d] a=%0d b=%0d got %0d/%b want %0d/%b", i, a, b, p, byp, exp_p, exp_byp); end
      if (exp_byp) begin
        checks++; if (start_rises != r0 || lat != 1) begin errors++; $display("FAIL rand_bypass[%0d] got rises=%0d lat=%0d want 0/1", i, start_rises - r0, lat); end
      end else begin
        checks++; if (din_first !== a || din_second !== b) begin errors++; $display("FAIL rand_din[%0d] got %0d,%0d want %0d,%0d", i, din_first, din_second, a, b); end
      end
    end
  endtask

  task automatic test_timeout();
    int n; bit ok;
    manual = 1'b1; man_done = 1'b0; man_p = 16'h1234;
    in_a = 16'd7; in_b = 16'd8; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef REPADD_FEED_TIMEOUT_EN
    n = 1;
    while (out_valid !== 1'b1 && n < LIMIT) begin @(posedge clk); #1; n++; end
    checks++; if (n != 3 + MAXW) begin errors++; $display("FAIL timeout_latency got %0d want %0d", n, 3 + MAXW); end
    checks++; if (out_valid !== 1'b1 || err !== 1'b1 || out_p !== '0 || mul_start !== 1'b0) begin errors++; $display("FAIL timeout_result got valid=%b err=%b p=%0d start=%b want 1/1/0/0", out_valid, err, out_p, mul_start); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (err !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL timeout_sticky got err=%b valid=%b want 1/1", err, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL timeout_clear got err=%b valid=%b rdy=%b want 0/0/1", err, out_valid, in_ready); end
    ok = 1'b1;
`else
    ok = 1'b1; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
    end
    checks++; if (!ok) begin errors++; $display("FAIL notimeout_wait got valid=%b err=%b rdy=%b want 0/0/0", out_valid, err, in_ready); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    manual = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL timeout_recover got rdy=%b err=%b want 1/0 (n=%0d ok=%b)", in_ready, err, n, ok); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_stale_done();
    test_random();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
